root_result_serializer: RTL and testbench
=========================================

ROOT_RESULT_SERIALIZER -- requirements
Module: root_result_serializer

Interface
REQ-001 SHALL have parameter CODE_DISTANCE_X, default 3: rows (i dimension).
REQ-002 SHALL have parameter CODE_DISTANCE_Z, default 2: columns (j dimension).
REQ-003 SHALL derive MEASUREMENT_ROUNDS = max(CODE_DISTANCE_X, CODE_DISTANCE_Z), PU_COUNT = X*Z*ROUNDS, PER_DIMENSION_WIDTH = clog2(ROUNDS), ADDRESS_WIDTH = 3*PER_DIMENSION_WIDTH.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port result_valid, input, 1: decoder result-ready level.
REQ-007 SHALL have port deadlock, input, 1: decoder deadlock level.
REQ-008 SHALL have port roots, input, ADDRESS_WIDTH*PU_COUNT: per-PU root address {k,i,j}; PU n occupies bits [n*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-009 SHALL have port out_data, output, 32: serialized result word.
REQ-010 SHALL have port out_valid, output, 1: out_data valid.
REQ-011 SHALL have port out_ready, input, 1: sink accepts the word.
REQ-012 SHALL have port busy, output, 1: frame capture/transmit in progress.
REQ-013 SHALL have port overrun, output, 1: sticky, a trigger was dropped.

Function
REQ-014 SHALL register result_valid and deadlock each cycle; trigger = input high while its registered copy is low (rising edge).
REQ-015 SHALL implement states IDLE, HEADER, ROOTS.
REQ-016 IDLE + result_valid trigger: SHALL copy roots into an internal snapshot register, latch flag=0, go HEADER next cycle.
REQ-017 IDLE + deadlock trigger: SHALL latch flag=1, go HEADER; snapshot not updated.
REQ-018 Both triggers same cycle: deadlock SHALL win (flag=1).
REQ-019 HEADER: out_valid=1, out_data = {flag, test_id[30:0]}; on out_valid&&out_ready: flag=1 -> IDLE, flag=0 -> ROOTS with index=0.
REQ-020 ROOTS: out_valid=1, out_data for snapshot entry index: bits[PER_DIMENSION_WIDTH-1:0]=j field (y), bits[8 +: PER_DIMENSION_WIDTH]=i field (x), bits[16 +: PER_DIMENSION_WIDTH]=k field (z), all other bits 0.
REQ-021 ROOTS: index SHALL advance by 1 per accepted word; entry n corresponds to n = i*Z + j + k*Z*X, so output order is k outer, i middle, j inner.
REQ-022 Acceptance of entry PU_COUNT-1 SHALL return to IDLE; out_valid low the following cycle.
REQ-023 Frame length SHALL be exactly 1+PU_COUNT words (normal) or 1 word (deadlock).
REQ-024 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable; out_valid SHALL never drop before acceptance.
REQ-025 Latency: trigger at edge N -> out_valid=1 with header in cycle after edge N; zero-wait sink gives one word per cycle.
REQ-026 test_id SHALL be a 31-bit counter, 0 after reset, incremented on header acceptance, wrapping 0x7FFFFFFF -> 0.
REQ-027 busy SHALL be 1 in HEADER and ROOTS, 0 in IDLE.
REQ-028 A trigger seen while not IDLE (including the final-word-acceptance cycle) SHALL be dropped and set overrun=1; the snapshot and current frame SHALL be unaffected.
REQ-029 Changes on roots after capture SHALL not affect the frame in progress.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, out_valid=0, out_data=0, busy=0, overrun=0, test_id=0, index=0, edge registers=0, regardless of state.
REQ-031 Reset mid-frame SHALL abandon the frame; no further words emitted; an input held high through reset release SHALL count as a rising edge next cycle.

Verification (X=3, Z=2: PU_COUNT=18, PER_DIMENSION_WIDTH=2)
REQ-032 Every root = own address, result_valid pulse, out_ready=1 -> words 0x00000000, 0x00000000, 0x00000001, 0x00000100, ..., entry 5 = 0x00000201, entry 17 = 0x00020201; 19 words in 19 consecutive cycles; busy drops after.
REQ-033 deadlock pulse after one normal frame -> single word 0x80000001, out_valid low next cycle, test_id becomes 2.
REQ-034 out_ready toggled pseudo-randomly -> same 19-word sequence, no duplicates or skips, out_data stable during stalls.
REQ-035 result_valid held high across three frames' duration -> exactly one frame; second rising edge mid-frame -> frame unchanged, overrun=1 until reset.
REQ-036 result_valid and deadlock rise same cycle -> header 0x80000000 only.
REQ-037 reset asserted at ROOTS index 7 -> next cycle out_valid=0, busy=0, overrun=0; next trigger emits header 0x00000000.

Source files
------------

// File: rtl/root_result_serializer.sv
// Serializes the decoder's per-PU root addresses as a framed word stream: a header word
// carrying a running test id (or the deadlock flag), then one word per PU for normal results.
module root_result_serializer #(
    parameter int unsigned CODE_DISTANCE_X = 3,
    parameter int unsigned CODE_DISTANCE_Z = 2,
    localparam int unsigned MEASUREMENT_ROUNDS =
        (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int unsigned PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    localparam int unsigned PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS),
    localparam int unsigned ADDRESS_WIDTH = 3 * PER_DIMENSION_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              result_valid,
    input  logic                              deadlock,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots,
    output logic [31:0]                       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              overrun
);
    localparam int unsigned INDEX_WIDTH = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(PU_COUNT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HEADER = 2'd1;
    localparam logic [1:0] ROOTS  = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic                             flag_q, flag_d;
    logic [30:0]                      test_id_q, test_id_d;
    logic [INDEX_WIDTH-1:0]           index_q, index_d;
    logic [ADDRESS_WIDTH*PU_COUNT-1:0] snapshot_q, snapshot_d;
    logic                             overrun_q, overrun_d;
    logic                             result_valid_q, deadlock_q;
    logic                             rv_trigger, dl_trigger, accept;
    logic [ADDRESS_WIDTH-1:0]         entry;

    assign rv_trigger = result_valid & ~result_valid_q;
    assign dl_trigger = deadlock & ~deadlock_q;
    assign accept     = out_valid & out_ready;
    assign entry      = snapshot_q[index_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        test_id_d  = test_id_q;
        index_d    = index_q;
        snapshot_d = snapshot_q;
        // Any trigger outside IDLE is dropped, including the final-word cycle.
        overrun_d  = overrun_q | ((state_q != IDLE) & (rv_trigger | dl_trigger));
        case (state_q)
            IDLE: begin
                if (dl_trigger) begin
                    flag_d  = 1'b1;
                    state_d = HEADER;
                end else if (rv_trigger) begin
                    flag_d     = 1'b0;
                    snapshot_d = roots;
                    state_d    = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    test_id_d = test_id_q + 31'd1;
                    index_d   = '0;
                    state_d   = flag_q ? IDLE : ROOTS;
                end
            end
            ROOTS: begin
                if (accept) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            flag_q         <= 1'b0;
            test_id_q      <= '0;
            index_q        <= '0;
            snapshot_q     <= '0;
            overrun_q      <= 1'b0;
            result_valid_q <= 1'b0;
            deadlock_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            flag_q         <= flag_d;
            test_id_q      <= test_id_d;
            index_q        <= index_d;
            snapshot_q     <= snapshot_d;
            overrun_q      <= overrun_d;
            result_valid_q <= result_valid;
            deadlock_q     <= deadlock;
        end
    end

    // Root address is packed {k,i,j}; the output spreads the fields across bytes.
    always_comb begin
        out_data = '0;
        case (state_q)
            HEADER: out_data = {flag_q, test_id_q};
            ROOTS: begin
                out_data[PER_DIMENSION_WIDTH-1:0] = entry[PER_DIMENSION_WIDTH-1:0];
                out_data[8 +: PER_DIMENSION_WIDTH] =
                    entry[PER_DIMENSION_WIDTH +: PER_DIMENSION_WIDTH];
                out_data[16 +: PER_DIMENSION_WIDTH] =
                    entry[2*PER_DIMENSION_WIDTH +: PER_DIMENSION_WIDTH];
            end
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state_q == HEADER) || (state_q == ROOTS);
    assign busy      = out_valid;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_root_result_serializer.sv
// Directed bench for root_result_serializer: expected words are queued as each frame is
// triggered and popped by a monitor as the sink accepts them.
module tb_root_result_serializer;
    localparam int NPU = 18;
    localparam int AW  = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             result_valid;
    logic             deadlock;
    logic [AW*NPU-1:0] roots;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic        stall_pending = 1'b0;
    logic [31:0] held_data = '0;

    root_result_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .result_valid(result_valid),
        .deadlock    (deadlock),
        .roots       (roots),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // PU m sits at k = m/6, i = (m%6)/2, j = m%2 for X=3, Z=2.
    function automatic logic [AW-1:0] addr_of(input int m);
        int k = m / 6;
        int i = (m % 6) / 2;
        int j = m % 2;
        return {2'(k), 2'(i), 2'(j)};
    endfunction

    function automatic logic [31:0] word_of(input int m);
        int k = m / 6;
        int i = (m % 6) / 2;
        int j = m % 2;
        return (32'(k) << 16) | (32'(i) << 8) | 32'(j);
    endfunction

    task automatic set_roots(input bit reversed);
        for (int n = 0; n < NPU; n++) roots[n*AW +: AW] = addr_of(reversed ? NPU - 1 - n : n);
    endtask

    task automatic push_frame(input int tid, input bit reversed, input int entries);
        exp_q.push_back({1'b0, 31'(tid)});
        for (int n = 0; n < entries; n++) exp_q.push_back(word_of(reversed ? NPU - 1 - n : n));
    endtask

    // Entered just after the trigger edge; counts cycles with out_valid until it drops.
    task automatic drain(input string tag, input int exp_cycles, input bit rand_ready);
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (!out_valid) break;
            n++;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (exp_cycles >= 0) check({tag, "_length"}, 32'(n), 32'(exp_cycles));
        out_ready = 1'b1;
    endtask

    task automatic pulse_rv();
        @(posedge clk);
        #1 result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted word must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", out_data, 32'hFFFF_FFFF);
                else check("word", out_data, exp_q.pop_front());
            end
            stall_pending = out_valid && !out_ready;
            held_data     = out_data;
        end
    end

    initial begin
        reset        = 1'b1;
        result_valid = 1'b0;
        deadlock     = 1'b0;
        out_ready    = 1'b1;
        set_roots(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Normal frame, own-address roots, zero-wait sink.
        push_frame(0, 1'b0, NPU);
        pulse_rv();
        drain("normal", 19, 1'b0);

        // Deadlock after one frame: single header with flag and test_id 1.
        exp_q.push_back(32'h8000_0001);
        @(posedge clk);
        #1 deadlock = 1'b1;
        @(posedge clk);
        #1 deadlock = 1'b0;
        drain("deadlock", 1, 1'b0);

        // Backpressured sink; roots scrambled after capture must not leak into the frame.
        push_frame(2, 1'b0, NPU);
        pulse_rv();
        roots = '1;
        drain("stall", -1, 1'b1);
        set_roots(1'b0);

        // Level held high: one frame only, no overrun.
        push_frame(3, 1'b0, NPU);
        @(posedge clk);
        #1 result_valid = 1'b1;
        @(posedge clk);
        #1;
        drain("held", 19, 1'b0);
        repeat (40) begin
            @(negedge clk);
            check("held_no_refire", out_valid, 1'b0);
        end
        check("held_overrun", overrun, 1'b0);
        #1 result_valid = 1'b0;

        // Second rising edge mid-frame is dropped and sets overrun.
        push_frame(4, 1'b0, NPU);
        pulse_rv();
        repeat (3) @(posedge clk);
        #1 result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        @(negedge clk);
        check("midframe_overrun", overrun, 1'b1);
        drain("midframe", -1, 1'b0);
        check("overrun_sticky", overrun, 1'b1);

        // Both levels high through reset release: both rise together, deadlock wins.
        @(posedge clk);
        #1 reset = 1'b1;
        result_valid = 1'b1;
        deadlock     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset2_overrun", overrun, 1'b0);
        check("reset2_valid", out_valid, 1'b0);
        exp_q.push_back(32'h8000_0000);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        deadlock     = 1'b0;
        drain("both", 1, 1'b0);

        // Reset while ROOTS shows entry 7: header plus entries 0..6 go out, then nothing.
        push_frame(1, 1'b0, 7);
        pulse_rv();
        repeat (2) @(posedge clk);
        #1 deadlock = 1'b1;
        @(posedge clk);
        #1 deadlock = 1'b0;
        @(negedge clk);
        check("abort_overrun_set", overrun, 1'b1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_overrun", overrun, 1'b0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fresh frame after reset with a reversed root pattern; test_id restarts at 0.
        set_roots(1'b1);
        push_frame(0, 1'b1, NPU);
        pulse_rv();
        drain("after_reset", 19, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
